// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC array sequencer.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int unsigned STALL_W = 16;

  // DIM cycles to fill the skew fifos plus 2*(DIM-1) to ripple through the array.
  function automatic int unsigned flush_cyc(input int unsigned dim);
    return 3 * dim - 2;
  endfunction

endpackage

// File: rtl/mac_seq_timer.sv
// Loadable down-counter with a zero flag; used as the flush timer.
module mac_seq_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  // Load wins over dec; the count parks at zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mac_seq.sv
// Control sequencer for the systolic MAC array: clear, feed, flush, drain.
// Define MAC_SEQ_PERF_EN to build the input-stall counter on stall_cnt.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned DIM   = 8,
  parameter int unsigned CNT_W = 8,
  localparam int unsigned ROW_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   k_len,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               fifo_en,
  output logic               zero_in,
  output logic               mac_en,
  output logic               mac_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ROW_W-1:0]   out_row,
  output logic               busy,
  output logic               done,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int unsigned FLUSH_CYC = flush_cyc(DIM);
  localparam int unsigned TMR_W     = $clog2(FLUSH_CYC + 1);
  localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYC - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(DIM - 1);

  seq_state_e       state_q;
  logic [CNT_W-1:0] k_last_q;
  logic [CNT_W-1:0] feed_cnt_q;
  logic [ROW_W-1:0] row_q;
  logic             feed_q;
  logic             flush_q;
  logic             clr_q;
  logic             drain_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             last_accept;
  logic             tmr_zero;

  assign accept      = feed_q & in_valid;
  assign last_accept = accept & (feed_cnt_q == k_last_q);

  mac_seq_timer #(
    .W(TMR_W)
  ) u_flush_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (last_accept),
    .load_val(FLUSH_LOAD),
    .dec     (flush_q),
    .zero    (tmr_zero)
  );

  // Output flags are registered alongside the state so every output is a flop
  // (or a flop ANDed with in_valid).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_last_q   <= '0;
      feed_cnt_q <= '0;
      row_q      <= '0;
      feed_q     <= 1'b0;
      flush_q    <= 1'b0;
      clr_q      <= 1'b0;
      drain_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            feed_cnt_q <= '0;
            busy_q     <= 1'b1;
            if (k_len != '0) begin
              k_last_q <= k_len - CNT_W'(1);
              clr_q    <= 1'b1;
              state_q  <= CLEAR;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        CLEAR: begin
          feed_q  <= 1'b1;
          state_q <= FEED;
        end
        FEED: begin
          if (last_accept) begin
            feed_q  <= 1'b0;
            flush_q <= 1'b1;
            state_q <= FLUSH;
          end else if (accept) begin
            feed_cnt_q <= feed_cnt_q + CNT_W'(1);
          end
        end
        FLUSH: begin
          if (tmr_zero) begin
            flush_q <= 1'b0;
            drain_q <= 1'b1;
            row_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_q == LAST_ROW) begin
              drain_q <= 1'b0;
              done_q  <= 1'b1;
              row_q   <= '0;
              state_q <= DONE;
            end else begin
              row_q <= row_q + ROW_W'(1);
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          feed_q  <= 1'b0;
          flush_q <= 1'b0;
          drain_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = feed_q;
  assign fifo_en   = accept | flush_q;
  assign mac_en    = accept | flush_q;
  assign zero_in   = flush_q;
  assign mac_clr   = clr_q;
  assign out_valid = drain_q;
  assign out_row   = row_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef MAC_SEQ_PERF_EN
  logic [STALL_W-1:0] stall_q;

  // Saturating count of FEED bubbles; holds after the job until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (feed_q && !in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: cycle table for a basic job plus corner sequences.
module tb_mac_seq;
  import mac_pkg::*;

  localparam int DIM   = 8;
  localparam int CNT_W = 8;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [CNT_W-1:0]   k_len;
  logic               in_valid;
  logic               in_ready;
  logic               fifo_en;
  logic               zero_in;
  logic               mac_en;
  logic               mac_clr;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_row;
  logic               busy;
  logic               done;
  logic [STALL_W-1:0] stall_cnt;

  mac_seq #(
    .DIM  (DIM),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_len    (k_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fifo_en  (fifo_en),
    .zero_in  (zero_in),
    .mac_en   (mac_en),
    .mac_clr  (mac_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .busy     (busy),
    .done     (done),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int sb_q[$];

  typedef struct {
    int         lo;
    int         hi;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {in_ready, fifo_en, mac_en, zero_in, mac_clr, out_valid, busy, done};
  endfunction

  task automatic push_rows();
    for (int i = 0; i < DIM; i++) sb_q.push_back(i);
  endtask

  task automatic drive(input logic s, input logic [CNT_W-1:0] k, input logic iv,
                       input logic ordy, input logic r = 1'b1);
    @(negedge clk);
    rst_n     = r;
    start     = s;
    k_len     = k;
    in_valid  = iv;
    out_ready = ordy;
    #1;
  endtask

  task automatic run_to_done(input logic hold, input logic [CNT_W-1:0] k, input int budget,
                             input string name, output int fe);
    bit found = 0;
    fe = 0;
    for (int i = 0; i < budget; i++) begin
      drive(hold, k, 1'b1, 1'b1);
      if (in_ready && fifo_en) fe++;
      if (done) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard: every handshaked row must match the next expected row index.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_row: got row %0d, expected none", out_row);
      end else begin
        chk("sb_row", 32'(out_row), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    logic pat[5];
    int   fe;
    int   nd;
    logic [7:0] exp;

    tbl[0] = '{0, 0, 8'b0000_0000};
    tbl[1] = '{1, 1, 8'b0000_1010};
    tbl[2] = '{2, 5, 8'b1110_0010};
    tbl[3] = '{6, 27, 8'b0111_0010};
    tbl[4] = '{28, 35, 8'b0000_0110};
    tbl[5] = '{36, 36, 8'b0000_0011};
    tbl[6] = '{37, 38, 8'b0000_0000};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 0; start = 0; k_len = '0; in_valid = 0; out_ready = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", 32'(outs()), 32'h0);
    chk("reset_row", 32'(out_row), 32'h0);
    chk("reset_stall", 32'(stall_cnt), 32'h0);

    // Basic job, k_len=4, in_valid and out_ready always high.
    for (int c = 0; c <= 38; c++) begin
      drive(c == 0, 8'd4, 1'b1, 1'b1);
      if (c == 0) push_rows();
      exp = 8'hxx;
      for (int t = 0; t < 7; t++) if (c >= tbl[t].lo && c <= tbl[t].hi) exp = tbl[t].exp;
      chk($sformatf("basic[%0d]", c), 32'(outs()), 32'(exp));
      if (c >= 28 && c <= 35) chk($sformatf("basic_row[%0d]", c), 32'(out_row), 32'(c - 28));
    end
    chk("basic_sb_empty", 32'(sb_q.size()), 0);

    // Input bubbles.
    drive(1'b1, 8'd3, 1'b1, 1'b1);
    push_rows();
    drive(1'b0, 8'd3, 1'b1, 1'b1);
    chk("bub_clr", 32'(mac_clr), 1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 8'd3, pat[i], 1'b1);
      chk($sformatf("bub_fe[%0d]", i), 32'(fifo_en), 32'(pat[i]));
      chk($sformatf("bub_mac[%0d]", i), 32'(mac_en), 32'(pat[i]));
      chk($sformatf("bub_rdy[%0d]", i), 32'(in_ready), 1);
      chk($sformatf("bub_zero[%0d]", i), 32'(zero_in), 0);
    end
    drive(1'b0, 8'd3, 1'b0, 1'b1);
    chk("bub_flush_zero", 32'(zero_in), 1);
    chk("bub_flush_fe", 32'(fifo_en), 1);
    chk("bub_flush_rdy", 32'(in_ready), 0);
`ifdef MAC_SEQ_PERF_EN
    chk("bub_stall", 32'(stall_cnt), 2);
`else
    chk("bub_stall", 32'(stall_cnt), 0);
`endif
    run_to_done(1'b0, 8'd3, 100, "bub", fe);
    drive(1'b0, 8'd3, 1'b0, 1'b1);
`ifdef MAC_SEQ_PERF_EN
    chk("bub_stall_hold", 32'(stall_cnt), 2);
`else
    chk("bub_stall_hold", 32'(stall_cnt), 0);
`endif
    chk("bub_sb_empty", 32'(sb_q.size()), 0);

    // Readout backpressure on row 2.
    drive(1'b1, 8'd1, 1'b1, 1'b1);
    push_rows();
    nd = 0;
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 8'd1, 1'b1, 1'b1);
      if (out_valid && out_row == 3'd1) begin
        nd = 1;
        break;
      end
    end
    chk("bp_reach_row1", 32'(nd), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'd1, 1'b1, 1'b0);
      chk($sformatf("bp_hold_row[%0d]", i), 32'(out_row), 2);
      chk($sformatf("bp_hold_valid[%0d]", i), 32'(out_valid), 1);
    end
    run_to_done(1'b0, 8'd1, 50, "bp", fe);
    chk("bp_sb_empty", 32'(sb_q.size()), 0);

    // k_len = 0: straight to DONE.
    drive(1'b1, 8'd0, 1'b1, 1'b1);
    chk("k0_idle_busy", 32'(busy), 0);
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    chk("k0_busy", 32'(busy), 1);
    chk("k0_done", 32'(done), 1);
    chk("k0_no_act", 32'({fifo_en, mac_en, mac_clr, in_ready}), 0);
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    chk("k0_after", 32'(outs()), 0);

    // Reset in the middle of FLUSH (flush cycle 10 = job cycle 14 for k_len=2).
    drive(1'b1, 8'd2, 1'b1, 1'b1);
    for (int c = 1; c <= 13; c++) drive(1'b0, 8'd2, 1'b1, 1'b1);
    drive(1'b0, 8'd2, 1'b1, 1'b1, 1'b0);
    chk("rst_was_flush", 32'(zero_in), 1);
    drive(1'b0, 8'd2, 1'b1, 1'b1);
    chk("rst_outs", 32'(outs()), 0);
    chk("rst_row", 32'(out_row), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 8'd2, 1'b1, 1'b1);
      if (done || busy) nd++;
    end
    chk("rst_no_done", 32'(nd), 0);
    drive(1'b1, 8'd1, 1'b1, 1'b1);
    push_rows();
    drive(1'b0, 8'd1, 1'b1, 1'b1);
    chk("rst_restart_clr", 32'(mac_clr), 1);
    run_to_done(1'b0, 8'd1, 50, "rst_restart", fe);
    chk("rst_restart_fe", 32'(fe), 1);
    chk("rst_sb_empty", 32'(sb_q.size()), 0);

    // start held through a k_len=255 job.
    drive(1'b1, 8'd255, 1'b1, 1'b1);
    push_rows();
    run_to_done(1'b1, 8'd255, 400, "hold", fe);
    chk("hold_feed_cycles", 32'(fe), 255);
    chk("hold_sb_empty", 32'(sb_q.size()), 0);
    drive(1'b1, 8'd255, 1'b1, 1'b1);
    chk("hold_idle_busy", 32'(busy), 0);
    chk("hold_idle_clr", 32'(mac_clr), 0);
    push_rows();
    drive(1'b0, 8'd255, 1'b1, 1'b1);
    chk("hold_second_clr", 32'(mac_clr), 1);
    run_to_done(1'b0, 8'd255, 400, "hold2", fe);
    chk("hold2_feed_cycles", 32'(fe), 255);
    drive(1'b0, 8'd0, 1'b1, 1'b1);
    chk("hold2_idle", 32'(busy), 0);
    chk("hold2_sb_empty", 32'(sb_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
